// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
// The opcode occupies the top OPCODE_WIDTH bits of every instruction word.
package instr_fetch_pkg;

  localparam int OPCODE_WIDTH = 4;
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = '1;
  localparam int DRAIN_CLKS = 6;
  localparam int DRAIN_CNT_W = $clog2(DRAIN_CLKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Host programming, datapath and status signals of the fetch unit.
// The master modport is the host/datapath side, the slave modport is the fetch unit.
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int INS_ADDR_WIDTH = 8,
  parameter int ADDR_WIDTH     = 10,
  parameter int INSTR_WIDTH    = OPCODE_WIDTH + 3 * ADDR_WIDTH
);
  logic                      prog_wen;
  logic [INS_ADDR_WIDTH-1:0] prog_addr;
  logic [INSTR_WIDTH-1:0]    prog_data;
  logic                      start;
  logic                      abort;
  logic [INS_ADDR_WIDTH-1:0] pc;
  logic [INSTR_WIDTH-1:0]    instruction;
  logic                      dp_rstn;
  logic                      busy;
  logic                      done;
  logic                      prog_err;
  logic [31:0]               cycle_count;

  modport master (
    output prog_wen, prog_addr, prog_data, start, abort, pc,
    input  instruction, dp_rstn, busy, done, prog_err, cycle_count
  );

  modport slave (
    input  prog_wen, prog_addr, prog_data, start, abort, pc,
    output instruction, dp_rstn, busy, done, prog_err, cycle_count
  );
endinterface

// File: rtl/instr_fetch_mem.sv
// Simple dual-port instruction memory: one write port, one registered read port.
// Read-first on a same-address collision; contents are never reset.
module instr_mem #(
  parameter int AW = 8,
  parameter int DW = 34
) (
  input  logic          clk,
  input  logic          i_wen,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_wen) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: host loads program in IDLE, then RUN fetches mem[pc]
// until a HALT opcode, DRAIN lets the datapath pipeline empty, DONE pulses completion.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int INS_ADDR_WIDTH = 8,
  parameter int ADDR_WIDTH     = 10,
  parameter int INSTR_WIDTH    = OPCODE_WIDTH + 3 * ADDR_WIDTH
) (
  input logic         clk,
  input logic         rstn,
  instr_fetch_if.slave fetch_bus
);
  fetch_state_t           r_state;
  fetch_state_t           w_state_next;
  logic [INSTR_WIDTH-1:0] w_rdata;
  logic [DRAIN_CNT_W-1:0] r_drain_cnt;
  logic                   r_prog_err;
  logic [31:0]            r_cycle_count;
  logic                   w_idle;
  logic                   w_active;
  logic                   w_start_ok;
  logic                   w_mem_wen;
  logic                   w_halt;
  logic                   w_drain_last;

  assign w_idle       = (r_state == IDLE);
  assign w_active     = (r_state == RUN) || (r_state == DRAIN);
  assign w_start_ok   = w_idle && fetch_bus.start && !fetch_bus.abort;
  assign w_mem_wen    = rstn && w_idle && fetch_bus.prog_wen;
  assign w_halt       = (w_rdata[INSTR_WIDTH-1 -: OPCODE_WIDTH] == OP_HALT);
  assign w_drain_last = (r_drain_cnt == DRAIN_CNT_W'(DRAIN_CLKS - 1));

  instr_mem #(
    .AW (INS_ADDR_WIDTH),
    .DW (INSTR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .i_wen   (w_mem_wen),
    .i_waddr (fetch_bus.prog_addr),
    .i_wdata (fetch_bus.prog_data),
    .i_raddr (fetch_bus.pc),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (fetch_bus.start) w_state_next = RUN;
      RUN:     if (w_halt) w_state_next = DRAIN;
      DRAIN:   if (w_drain_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    // abort beats every transition, including a start in IDLE
    if (fetch_bus.abort) begin
      w_state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_drain_cnt   <= '0;
      r_prog_err    <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_state <= w_state_next;

      if (r_state == DRAIN && w_state_next == DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 1'b1;
      end else begin
        r_drain_cnt <= '0;
      end

      if (w_start_ok) begin
        r_prog_err <= 1'b0;
      end else if (fetch_bus.prog_wen && !w_idle) begin
        r_prog_err <= 1'b1;
      end

      if (w_start_ok) begin
        r_cycle_count <= '0;
      end else if (w_active && r_cycle_count != '1) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end
    end
  end

  // The HALT word itself is presented as a NOP.
  assign fetch_bus.instruction = (r_state == RUN && !w_halt) ? w_rdata : '0;
  assign fetch_bus.dp_rstn     = w_active;
  assign fetch_bus.busy        = w_active;
  assign fetch_bus.done        = (r_state == DONE);
  assign fetch_bus.prog_err    = r_prog_err;
  assign fetch_bus.cycle_count = r_cycle_count;
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: a behavioural model predicts every
// cycle's outputs into a queue, a negedge monitor pops and compares them.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int IAW = 8;
  localparam int AW  = 10;
  localparam int IW  = OPCODE_WIDTH + 3 * AW;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if #(.INS_ADDR_WIDTH(IAW), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) fbus ();

  instr_fetch #(
    .INS_ADDR_WIDTH (IAW),
    .ADDR_WIDTH     (AW),
    .INSTR_WIDTH    (IW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .fetch_bus (fbus.slave)
  );

  typedef struct {
    logic [IW-1:0] instr;
    logic          dp_rstn;
    logic          busy;
    logic          done;
    logic          prog_err;
    logic [31:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // behavioural reference state
  logic [IW-1:0] m_mem [256];
  logic [IW-1:0] m_rd = '0;
  fetch_state_t  m_mode = IDLE;
  logic          m_err = 1'b0;
  logic [31:0]   m_cnt = '0;
  int            m_drain_left = 0;

  // datapath pc model: held at 0 while in reset, advances every second clock
  logic [IAW-1:0] cur_pc = '0;
  bit             dp_phase = 1'b0;

  function automatic logic [IW-1:0] rand_word(input bit halt);
    logic [63:0]   r;
    logic [IW-1:0] w;
    r = {$urandom, $urandom};
    w = r[IW-1:0];
    w[IW-1 -: OPCODE_WIDTH] = halt ? OP_HALT : OPCODE_WIDTH'($urandom_range(0, 14));
    return w;
  endfunction

  function automatic bit is_halt(input logic [IW-1:0] w);
    return w[IW-1 -: OPCODE_WIDTH] == OP_HALT;
  endfunction

  task automatic model_edge(input bit wen, input logic [IAW-1:0] addr, input logic [IW-1:0] data,
                            input bit st, input bit ab, input bit rs, input logic [IAW-1:0] pc);
    logic [IW-1:0] rd_old;
    fetch_state_t  mode_old;
    exp_t          e;
    rd_old   = m_rd;
    mode_old = m_mode;
    m_rd     = m_mem[pc];
    if (!rs) begin
      m_mode = IDLE; m_err = 1'b0; m_cnt = '0; m_drain_left = 0;
    end else begin
      if ((mode_old == RUN || mode_old == DRAIN) && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (mode_old != IDLE && wen) m_err = 1'b1;
      if (ab) begin
        m_mode = IDLE;
      end else begin
        case (mode_old)
          IDLE:  if (st) begin m_mode = RUN; m_err = 1'b0; m_cnt = '0; end
          RUN:   if (is_halt(rd_old)) begin m_mode = DRAIN; m_drain_left = DRAIN_CLKS; end
          DRAIN: begin m_drain_left--; if (m_drain_left == 0) m_mode = DONE; end
          default: m_mode = IDLE;
        endcase
      end
      if (mode_old == IDLE && wen) m_mem[addr] = data;
    end
    e.busy     = (m_mode == RUN || m_mode == DRAIN);
    e.dp_rstn  = e.busy;
    e.done     = (m_mode == DONE);
    e.instr    = (m_mode == RUN && !is_halt(m_rd)) ? m_rd : '0;
    e.prog_err = m_err;
    e.cnt      = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit wen = 0, input logic [IAW-1:0] addr = '0,
                      input logic [IW-1:0] data = '0, input bit st = 0,
                      input bit ab = 0, input bit rs = 1);
    fbus.prog_wen  = wen;
    fbus.prog_addr = addr;
    fbus.prog_data = data;
    fbus.start     = st;
    fbus.abort     = ab;
    fbus.pc        = cur_pc;
    rstn           = rs;
    model_edge(wen, addr, data, st, ab, rs, cur_pc);
    @(posedge clk);
    #1;
    if (m_mode == RUN || m_mode == DRAIN) begin
      dp_phase = ~dp_phase;
      if (!dp_phase) cur_pc = cur_pc + 1'b1;
    end else begin
      cur_pc   = '0;
      dp_phase = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("instruction", 64'(fbus.instruction), 64'(e.instr));
        chk("dp_rstn",     64'(fbus.dp_rstn),     64'(e.dp_rstn));
        chk("busy",        64'(fbus.busy),        64'(e.busy));
        chk("done",        64'(fbus.done),        64'(e.done));
        chk("prog_err",    64'(fbus.prog_err),    64'(e.prog_err));
        chk("cycle_count", 64'(fbus.cycle_count), 64'(e.cnt));
      end
    end
  end

  initial begin
    int guard;
    fbus.prog_wen = 1'b0; fbus.prog_addr = '0; fbus.prog_data = '0;
    fbus.start = 1'b0; fbus.abort = 1'b0; fbus.pc = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;

    // reset state
    step(.rs(0)); step(.rs(0));

    // fill memory with non-HALT words, then two ops and HALT at 2
    for (int a = 0; a < 256; a++) step(.wen(1), .addr(IAW'(a)), .data(rand_word(0)));
    step(.wen(1), .addr(8'd2), .data(rand_word(1)));

    // basic run
    step(.st(1)); idle(24);

    // write during RUN ignored, flags prog_err; next start clears it
    step(.st(1)); idle(2);
    step(.wen(1), .addr(8'd0), .data(IW'(34'hFFFF)));
    idle(22);
    step(.st(1)); idle(24);

    // abort four clocks into RUN
    step(.st(1)); idle(3); step(.ab(1)); idle(4);

    // reset mid-DRAIN, then re-run without reloading
    step(.st(1));
    guard = 0;
    while (m_mode != DRAIN && guard < 50) begin step(); guard++; end
    chk("reach_drain", 64'(guard < 50), 64'd1);
    idle(2); step(.rs(0)); idle(2);
    step(.st(1)); idle(24);

    // start+abort together in IDLE; write+start together
    step(.st(1), .ab(1)); idle(2);
    step(.wen(1), .addr(8'd5), .data(rand_word(0)), .st(1)); idle(24);

    // randomized runs with random HALT position and stray writes/aborts
    for (int r = 0; r < 4; r++) begin
      step(.wen(1), .addr(IAW'($urandom_range(3, 6))), .data(rand_word(1)));
      step(.st(1));
      for (int k = 0; k < 40; k++) begin
        step(.wen($urandom_range(0, 7) == 0), .addr(IAW'($urandom_range(0, 255))),
             .data(rand_word(0)), .ab($urandom_range(0, 39) == 0));
      end
      step(.ab(1)); idle(1);
    end

    // no HALT anywhere near, pc wraps 255 -> 0 and fetching continues
    for (int a = 0; a < 8; a++) step(.wen(1), .addr(IAW'(a)), .data(rand_word(0)));
    for (int a = 248; a < 256; a++) step(.wen(1), .addr(IAW'(a)), .data(rand_word(0)));
    step(.st(1));
    cur_pc = 8'd253; dp_phase = 1'b0;
    idle(20);
    step(.ab(1)); idle(2);

    @(negedge clk); #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters SHALL be: INS_ADDR_WIDTH, default 8, instruction address width; ADDR_WIDTH, default 10, BRAM address width; INSTR_WIDTH, default OPCODE_WIDTH+3*ADDR_WIDTH, instruction word width.
REQ-002 Ports SHALL be:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- prog_wen  in  1  host program-memory write strobe
- prog_addr  in  INS_ADDR_WIDTH  host write address
- prog_data  in  INSTR_WIDTH  host write data
- start  in  1  begin execution at address 0
- abort  in  1  force return to IDLE
- pc  in  INS_ADDR_WIDTH  program counter from the datapath
- instruction  out  INSTR_WIDTH  instruction to the datapath
- dp_rstn  out  1  datapath reset, active-low
- busy  out  1  state is RUN or DRAIN
- done  out  1  one-cycle completion pulse
- prog_err  out  1  sticky illegal-write flag
- cycle_count  out  32  clocks spent in RUN+DRAIN

Function
REQ-003 Instruction memory SHALL hold 2^INS_ADDR_WIDTH words of INSTR_WIDTH bits, with one write port (host) and one registered read port (pc).
REQ-004 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-005 In IDLE with prog_wen=1, mem[prog_addr] SHALL be written with prog_data on that clock edge.
REQ-006 prog_wen=1 in any state other than IDLE SHALL be ignored and SHALL set prog_err, which clears only on reset or on an accepted start.
REQ-007 IDLE->RUN SHALL occur on start=1. start SHALL be ignored outside IDLE. prog_wen and start asserted together in IDLE SHALL perform the write, then enter RUN.
REQ-008 dp_rstn SHALL be 0 in IDLE and DONE and 1 in RUN and DRAIN, so that the datapath pc and pipeline begin from 0 on entry to RUN.
REQ-009 In RUN, instruction SHALL equal mem[pc] registered, with 1-clk latency from pc. In all other states instruction SHALL be all-zeros (NOP: write_en=0).
REQ-010 RUN->DRAIN SHALL occur when the registered instruction's opcode field (MSBs) equals OP_HALT. The HALT word itself SHALL be replaced by NOP on the output.
REQ-011 DRAIN SHALL last exactly DRAIN_CLKS=6 clocks (3 pipeline advances at half rate), outputting NOP, then go to DONE.
REQ-012 DONE SHALL pulse done=1 for one clock, then go to IDLE.
REQ-013 pc wrap from max to 0 in RUN SHALL continue fetching; there SHALL be no implicit halt.
REQ-014 abort=1 SHALL move any state to IDLE on the next edge with no done pulse; cycle_count SHALL hold its value.
REQ-015 cycle_count SHALL clear on an accepted start, increment each clock in RUN or DRAIN, and saturate at 2^32-1.
REQ-016 If abort and start are asserted together in IDLE, abort SHALL win and the state SHALL stay IDLE.

Reset
REQ-017 On rstn=0, the block SHALL set: state=IDLE, instruction=0, dp_rstn=0, busy=0, done=0, prog_err=0, cycle_count=0, drain counter=0.
REQ-018 Memory contents SHALL NOT be cleared by reset.
REQ-019 Reset during RUN or DRAIN SHALL take effect on the next edge and override all other inputs.

Structure
REQ-020 OPCODE_WIDTH, OP_HALT (all ones in the opcode field), DRAIN_CLKS and the FSM state enum SHALL live in the shared params package.
REQ-021 The memory SHALL be a sub-module, instr_mem (1W/1R, registered read), inferable as BRAM.

Verification
REQ-022 Load 3 words (two ops, then HALT at addr 2), start, with the model pc advancing every 2 clk -> instructions appear in order, HALT is replaced by NOP, busy stays high for RUN plus 6 clocks, done pulses once, and cycle_count matches the model.
REQ-023 prog_wen during RUN (addr 0, data 0xFFFF) -> mem[0] is unchanged on re-run and prog_err=1; the next start clears prog_err.
REQ-024 abort 4 clocks into RUN -> IDLE next edge, dp_rstn=0, no done pulse, instruction=0.
REQ-025 rstn low mid-DRAIN -> all outputs take their reset values; the program re-runs correctly without reloading.
REQ-026 Program with no HALT and pc driven 255->0 -> fetch continues from mem[0] and busy stays 1.
REQ-027 start and abort together in IDLE -> stays IDLE and cycle_count is unchanged.
